// File: rtl/vip_stream_pkg.sv
// Shared types and constants for the synthetic video stream generator.
// Optional build macro: VIP_STREAM_GEN_LFSR_EN (pattern 3 becomes an LFSR).
package vip_stream_pkg;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_AUX   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Registered output bundle, one field per stream output
    typedef struct packed {
        logic       vsync;
        logic       href;
        logic       clken;
        logic [7:0] y;
        logic       frame_done;
        logic       busy;
    } vid_out_t;

    // x^8+x^6+x^5+x^4+1 Fibonacci step, shifted left with feedback into bit 0
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/vip_video_stream_gen_if.sv
// Control and pixel-stream signals of the video stream generator.
interface vip_video_stream_gen_if;

    logic       enable;
    logic [1:0] pattern_sel;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_Y;
    logic       frame_done;
    logic       busy;

    modport master (
        input  enable, pattern_sel,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img_Y, frame_done, busy
    );

    modport slave (
        output enable, pattern_sel,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img_Y, frame_done, busy
    );

endinterface

// File: rtl/vip_timing_cnt.sv
// Pixel-slot divider, horizontal and vertical counters plus region decode.
module vip_timing_cnt #(
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned IMG_VDISP = 480,
    parameter int unsigned H_BLANK   = 160,
    parameter int unsigned VSYNC_LEN = 2,
    parameter int unsigned V_BACK    = 2,
    parameter int unsigned V_FRONT   = 2,
    parameter int unsigned CLKEN_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       run,
    output logic       tick_c,
    output logic       eof_c,
    output logic       vsync_c,
    output logic       href_c,
    output logic [7:0] x_c,
    output logic [7:0] y_c
);

    localparam int unsigned H_TOTAL = IMG_HDISP + H_BLANK;
    localparam int unsigned V_TOTAL = VSYNC_LEN + V_BACK + IMG_VDISP + V_FRONT;
    localparam int unsigned V_ACT0  = VSYNC_LEN + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

    logic [DW-1:0] div_q;
    logic [HW-1:0] hcnt_q;
    logic [VW-1:0] vcnt_q;
    logic          slot_end_c;
    logic          line_end_c;

    assign slot_end_c = (div_q == DW'(CLKEN_DIV - 1));
    assign line_end_c = slot_end_c && (hcnt_q == HW'(H_TOTAL - 1));
    assign eof_c      = line_end_c && (vcnt_q == VW'(V_TOTAL - 1));
    assign tick_c     = (div_q == '0);
    assign vsync_c    = (vcnt_q < VW'(VSYNC_LEN));
    assign href_c     = (vcnt_q >= VW'(V_ACT0)) && (vcnt_q < VW'(V_ACT0 + IMG_VDISP))
                        && (hcnt_q < HW'(IMG_HDISP));
    assign x_c        = 8'(hcnt_q);
    assign y_c        = 8'(vcnt_q - VW'(V_ACT0));

    // Slot divider, then pixel slot, then line; all wrap together at end of frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (clr) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (run) begin
            div_q <= slot_end_c ? '0 : div_q + DW'(1);
            if (slot_end_c) begin
                hcnt_q <= (hcnt_q == HW'(H_TOTAL - 1)) ? '0 : hcnt_q + HW'(1);
            end
            if (line_end_c) begin
                vcnt_q <= (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + VW'(1);
            end
        end
    end

endmodule

// File: rtl/vip_video_stream_gen.sv
// Synthetic vsync/href/clken/Y video source with selectable test patterns.
// Optional build macro: VIP_STREAM_GEN_LFSR_EN (pattern 3 = per-frame LFSR
// instead of the frame counter).
module vip_video_stream_gen
    import vip_stream_pkg::*;
#(
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned IMG_VDISP = 480,
    parameter int unsigned H_BLANK   = 160,
    parameter int unsigned VSYNC_LEN = 2,
    parameter int unsigned V_BACK    = 2,
    parameter int unsigned V_FRONT   = 2,
    parameter int unsigned CLKEN_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vip_video_stream_gen_if.master vid
);

    state_t     state_q, state_d;
    logic [1:0] pat_q, pat_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    vid_out_t   out_q, out_d;

    logic       run_c, start_c, clken_c;
    logic       tick_c, eof_c, vsync_c, href_c;
    logic [7:0] x_c, y_c, aux_c, pix_c;

    assign run_c   = (state_q == ST_RUN);
    assign start_c = (state_q == ST_IDLE) && vid.enable;
    assign clken_c = run_c && href_c && tick_c;

    vip_timing_cnt #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .H_BLANK   (H_BLANK),
        .VSYNC_LEN (VSYNC_LEN),
        .V_BACK    (V_BACK),
        .V_FRONT   (V_FRONT),
        .CLKEN_DIV (CLKEN_DIV)
    ) u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_c),
        .run     (run_c),
        .tick_c  (tick_c),
        .eof_c   (eof_c),
        .vsync_c (vsync_c),
        .href_c  (href_c),
        .x_c     (x_c),
        .y_c     (y_c)
    );

`ifdef VIP_STREAM_GEN_LFSR_EN
    logic [7:0] lfsr_q;

    // Reseed at every frame start, step after each emitted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else if (start_c || (run_c && eof_c && vid.enable)) begin
            lfsr_q <= LFSR_SEED;
        end else if (clken_c) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign aux_c = lfsr_q;
`else
    assign aux_c = frame_cnt_q;
`endif

    // Test-pattern select on the frame-latched pattern code
    always_comb begin
        pix_c = 8'h00;
        case (pat_q)
            PAT_HRAMP: pix_c = x_c;
            PAT_VRAMP: pix_c = y_c;
            PAT_CHECK: pix_c = (x_c[3] ^ y_c[3]) ? 8'hFF : 8'h00;
            PAT_AUX:   pix_c = aux_c;
            default:   pix_c = 8'h00;
        endcase
    end

    // Frame-boundary FSM, frame bookkeeping and output decode
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        out_d       = '0;
        case (state_q)
            ST_IDLE: begin
                if (vid.enable) begin
                    state_d = ST_RUN;
                    pat_d   = vid.pattern_sel;
                end
            end
            ST_RUN: begin
                out_d.vsync      = vsync_c;
                out_d.href       = href_c;
                out_d.clken      = clken_c;
                out_d.y          = clken_c ? pix_c : 8'h00;
                out_d.frame_done = eof_c;
                out_d.busy       = 1'b1;
                if (eof_c) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (vid.enable) begin
                        pat_d = vid.pattern_sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, frame counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            frame_cnt_q <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            out_q       <= out_d;
        end
    end

    assign vid.post_frame_vsync = out_q.vsync;
    assign vid.post_frame_href  = out_q.href;
    assign vid.post_frame_clken = out_q.clken;
    assign vid.post_img_Y       = out_q.y;
    assign vid.frame_done       = out_q.frame_done;
    assign vid.busy             = out_q.busy;

endmodule

// File: tb/tb_vip_video_stream_gen.sv
// Bench for vip_video_stream_gen: three configurations (8x4, 16x16, 8x4 at
// one pixel per 3 clocks) checked every cycle against a frame-index model,
// plus directed sequences for latency, frame length, stop and reset.
module tb_vip_video_stream_gen;
    import vip_stream_pkg::*;

    localparam int NDUT = 3;
    localparam int HB = 4, VS = 1, VB = 1, VF = 1;
    localparam int B_VS = 0, B_HR = 1, B_CK = 2, B_FD = 3, B_BZ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en [NDUT];
    logic [1:0] ps [NDUT];
    vid_out_t   o [NDUT];
    vid_out_t   exp_o [NDUT];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic chk_on = 1'b0;

    vip_video_stream_gen_if ifa ();
    vip_video_stream_gen_if ifb ();
    vip_video_stream_gen_if ifc ();

    assign ifa.enable = en[0];
    assign ifa.pattern_sel = ps[0];
    assign ifb.enable = en[1];
    assign ifb.pattern_sel = ps[1];
    assign ifc.enable = en[2];
    assign ifc.pattern_sel = ps[2];
    assign o[0] = {ifa.post_frame_vsync, ifa.post_frame_href, ifa.post_frame_clken,
                   ifa.post_img_Y, ifa.frame_done, ifa.busy};
    assign o[1] = {ifb.post_frame_vsync, ifb.post_frame_href, ifb.post_frame_clken,
                   ifb.post_img_Y, ifb.frame_done, ifb.busy};
    assign o[2] = {ifc.post_frame_vsync, ifc.post_frame_href, ifc.post_frame_clken,
                   ifc.post_img_Y, ifc.frame_done, ifc.busy};

    vip_video_stream_gen #(.IMG_HDISP(8), .IMG_VDISP(4), .H_BLANK(4), .VSYNC_LEN(1),
        .V_BACK(1), .V_FRONT(1), .CLKEN_DIV(1)) dut_a (.clk(clk), .rst_n(rst_n), .vid(ifa));
    vip_video_stream_gen #(.IMG_HDISP(16), .IMG_VDISP(16), .H_BLANK(4), .VSYNC_LEN(1),
        .V_BACK(1), .V_FRONT(1), .CLKEN_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .vid(ifb));
    vip_video_stream_gen #(.IMG_HDISP(8), .IMG_VDISP(4), .H_BLANK(4), .VSYNC_LEN(1),
        .V_BACK(1), .V_FRONT(1), .CLKEN_DIV(3)) dut_c (.clk(clk), .rst_n(rst_n), .vid(ifc));

    function automatic int hd(input int i); return (i == 1) ? 16 : 8; endfunction
    function automatic int vd(input int i); return (i == 1) ? 16 : 4; endfunction
    function automatic int dv(input int i); return (i == 2) ? 3 : 1; endfunction
    function automatic int frame_len(input int i);
        return (hd(i) + HB) * dv(i) * (VS + VB + vd(i) + VF);
    endfunction

    function automatic logic [7:0] lfsr_ref(input int p);
        logic [7:0] s;
        s = 8'hA5;
        for (int j = 0; j < p; j++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
    endfunction

    // Expected outputs for clock k (0-based) of a frame, from plain index arithmetic
    function automatic vid_out_t ref_out(input int i, input int k, input logic [1:0] pat,
                                         input logic [7:0] fc);
        vid_out_t e;
        int line_len, line, r, slot, ph, yy;
        line_len = (hd(i) + HB) * dv(i);
        line = k / line_len;
        r = k % line_len;
        slot = r / dv(i);
        ph = r % dv(i);
        yy = line - (VS + VB);
        e = '0;
        e.busy = 1'b1;
        e.frame_done = (k == frame_len(i) - 1);
        e.vsync = (line < VS);
        e.href = (yy >= 0) && (yy < vd(i)) && (slot < hd(i));
        e.clken = e.href && (ph == 0);
        if (e.clken) begin
            case (pat)
                2'd0: e.y = 8'(slot);
                2'd1: e.y = 8'(yy);
                2'd2: e.y = ((((slot >> 3) ^ (yy >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
                default: begin
`ifdef VIP_STREAM_GEN_LFSR_EN
                    e.y = lfsr_ref(yy * hd(i) + slot);
`else
                    e.y = fc;
`endif
                end
            endcase
        end
        return e;
    endfunction

    int         m_k [NDUT];
    logic       m_run [NDUT];
    logic [1:0] m_pat [NDUT];
    logic [7:0] m_fc [NDUT];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: frame position index per DUT, enable/pattern honoured only at frame edges
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDUT; i++) begin
                m_run[i] <= 1'b0;
                m_k[i] <= 0;
                m_pat[i] <= 2'd0;
                m_fc[i] <= 8'd0;
                exp_o[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                exp_o[i] <= m_run[i] ? ref_out(i, m_k[i], m_pat[i], m_fc[i]) : '0;
                if (!m_run[i]) begin
                    if (en[i]) begin
                        m_run[i] <= 1'b1;
                        m_k[i] <= 0;
                        m_pat[i] <= ps[i];
                    end
                end else if (m_k[i] == frame_len(i) - 1) begin
                    m_k[i] <= 0;
                    m_fc[i] <= m_fc[i] + 8'd1;
                    if (en[i]) m_pat[i] <= ps[i];
                    else m_run[i] <= 1'b0;
                end else begin
                    m_k[i] <= m_k[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // Per-cycle comparison of every DUT against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NDUT; i++) check($sformatf("stream_dut%0d", i), int'(o[i]), int'(exp_o[i]));
        end
    end

    function automatic logic fld(input vid_out_t v, input int b);
        case (b)
            B_VS: return v.vsync;
            B_HR: return v.href;
            B_CK: return v.clken;
            B_FD: return v.frame_done;
            default: return v.busy;
        endcase
    endfunction

    task automatic wait_bit(input int i, input int b, input logic val, input int maxc, output int n);
        n = 0;
        while (fld(o[i], b) != val && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) begin
            total++;
            bad++;
            $display("FAIL wait_dut%0d_bit%0d: got timeout after %0d cycles, expected level %0d", i, b, n, val);
        end
    endtask

    typedef struct {
        int x;
        int y;
        logic [7:0] y_exp;
    } chk_vec_t;
    chk_vec_t tbl [10];

    int n, c0, c1, bursts, hcl, ck, phase_bad;
    logic prev;
    logic [7:0] first_y, second_y;
    logic [7:0] pixq [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 8'h00};  tbl[1] = '{7, 0, 8'h00};
        tbl[2] = '{8, 0, 8'hFF};  tbl[3] = '{15, 0, 8'hFF};
        tbl[4] = '{0, 8, 8'hFF};  tbl[5] = '{7, 8, 8'hFF};
        tbl[6] = '{8, 8, 8'h00};  tbl[7] = '{15, 8, 8'h00};
        tbl[8] = '{3, 15, 8'hFF}; tbl[9] = '{12, 7, 8'hFF};
        for (int i = 0; i < NDUT; i++) begin
            en[i] = 1'b0;
            ps[i] = 2'd0;
        end
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        for (int i = 0; i < NDUT; i++) check("reset_out", int'(o[i]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(o[0].busy), 0);

        // Basic frame on A: latency, vsync length, bursts, frame length
        en[0] = 1'b1;
        ps[0] = 2'd0;
        @(negedge clk);
        check("vsync_lat0", int'(o[0].vsync), 0);
        @(negedge clk);
        check("vsync_lat1", int'(o[0].vsync), 1);
        c0 = cyc;
        n = 0;
        while (o[0].vsync && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("vsync_len", n, 12);
        bursts = 0; hcl = 0; prev = 1'b0; n = 0;
        while (!o[0].frame_done && n < 200) begin
            if (o[0].href) begin
                hcl++;
                if (!prev) bursts++;
            end
            prev = o[0].href;
            n++;
            @(negedge clk);
        end
        check("href_bursts", bursts, 4);
        check("href_clocks", hcl, 32);
        check("frame_len", cyc - c0 + 1, 84);
        c1 = cyc;
        @(negedge clk);
        wait_bit(0, B_FD, 1'b1, 200, n);
        check("frame_period", cyc - c1, 84);

        // Checker pattern on B, spot pixels from a table
        en[1] = 1'b1;
        ps[1] = 2'd2;
        @(negedge clk);
        pixq.delete();
        n = 0;
        while (!o[1].frame_done && n < 1000) begin
            if (o[1].clken) pixq.push_back(o[1].y);
            n++;
            @(negedge clk);
        end
        en[1] = 1'b0;
        check("chk_pix_count", pixq.size(), 256);
        for (int t = 0; t < 10; t++) begin
            if (tbl[t].y * 16 + tbl[t].x < pixq.size())
                check($sformatf("chk_x%0d_y%0d", tbl[t].x, tbl[t].y),
                      int'(pixq[tbl[t].y * 16 + tbl[t].x]), int'(tbl[t].y_exp));
            else
                check($sformatf("chk_x%0d_y%0d_present", tbl[t].x, tbl[t].y), pixq.size(), 256);
        end

        // Pixel rate on C: 24-clock href bursts, clken every 3rd clock
        en[2] = 1'b1;
        wait_bit(2, B_HR, 1'b1, 500, n);
        hcl = 0; ck = 0; phase_bad = 0;
        while (o[2].href && hcl < 100) begin
            if (o[2].clken) begin
                ck++;
                if (hcl % 3 != 0) phase_bad++;
            end
            hcl++;
            @(negedge clk);
        end
        en[2] = 1'b0;
        check("c_href_len", hcl, 24);
        check("c_clken_cnt", ck, 8);
        check("c_clken_phase", phase_bad, 0);

        // Stop at frame boundary with a mid-frame pattern change
        @(negedge clk);
        wait_bit(0, B_FD, 1'b1, 200, n);
        c1 = cyc;
        repeat (20) @(negedge clk);
        en[0] = 1'b0;
        ps[0] = 2'd1;
        @(negedge clk);
        wait_bit(0, B_FD, 1'b1, 200, n);
        check("stop_len", cyc - c1, 84);
        @(negedge clk);
        check("stop_busy", int'(o[0].busy), 0);
        check("stop_outputs", int'(o[0]), 0);
        en[0] = 1'b1;
        wait_bit(0, B_HR, 1'b1, 200, n);
        wait_bit(0, B_HR, 1'b0, 20, n);
        wait_bit(0, B_HR, 1'b1, 20, n);
        check("vramp_y1", int'(o[0].y), 1);

        // Reset mid-frame, then restart on pattern 3
        repeat (20) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) check("rst_async", int'(o[i]), 0);
        @(negedge clk);
        ps[0] = 2'd3;
        en[0] = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_vsync_lat0", int'(o[0].vsync), 0);
        @(negedge clk);
        check("rst_vsync_lat1", int'(o[0].vsync), 1);
        for (int f = 0; f < 3; f++) begin
            wait_bit(0, B_CK, 1'b1, 200, n);
            first_y = o[0].y;
            @(negedge clk);
            wait_bit(0, B_CK, 1'b1, 10, n);
            second_y = o[0].y;
`ifdef VIP_STREAM_GEN_LFSR_EN
            check($sformatf("pat3_f%0d_first", f), int'(first_y), 'hA5);
            check($sformatf("pat3_f%0d_second", f), int'(second_y), 'h4A);
`else
            check($sformatf("pat3_f%0d_first", f), int'(first_y), f);
            check($sformatf("pat3_f%0d_second", f), int'(second_y), f);
`endif
            wait_bit(0, B_FD, 1'b1, 200, n);
            @(negedge clk);
        end

        // Random enable/pattern traffic on all DUTs, one async reset pulse
        for (int r = 0; r < 1500; r++) begin
            for (int i = 0; i < NDUT; i++) begin
                if ($urandom_range(0, 99) < 3) en[i] = ~en[i];
                if ($urandom_range(0, 99) < 5) ps[i] = 2'($urandom_range(0, 3));
            end
            if (r == 700) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
